// File: rtl/bus_control_ws.sv
`default_nettype none
// ============================================================================
// Module   : bus_control_ws
// Purpose  : 68000-style bus controller. Decodes the address map, keeps the
//            PROM bootstrap overlay, and acknowledges cycles through a
//            per-region wait-state FSM with I/O handshake, bus-error timeout
//            and a single-step stepper. All state changes on MCLK_IN negedge.
// Revision : 1.0 - initial release
// ============================================================================
module bus_control_ws #(
  parameter int         PROM_WAIT        = 2,
  parameter int         SRAM_WAIT        = 0,
  parameter int         IO_TIMEOUT       = 64,
  parameter int         UNMAPPED_TIMEOUT = 16,
  parameter logic [3:0] PROM_BASE        = 4'hF,
  parameter logic [3:0] IO_BASE          = 4'h1
) (
  input  logic        MCLK_IN,
  input  logic        RUN_IN,
  input  logic        STEPEN_IN,
  input  logic        STEP_IN,
  input  logic        AS_IN,
  input  logic        WR_IN,
  input  logic        UDS_IN,
  input  logic        LDS_IN,
  input  logic [23:0] ADDR_IN,
  input  logic        IO_ACK_IN,
  output logic        DTACK,
  output logic        BERR,
  output logic        PROMCS0,
  output logic        PROMCS1,
  output logic        SRAMCS0,
  output logic        SRAMCS1,
  output logic        OE,
  output logic        IOSEL,
  output logic        BOOTSTRAPPED
);

  // Counter must hold the largest load value: either timeout or a 4-bit wait.
  localparam int MAX_TO    = (IO_TIMEOUT > UNMAPPED_TIMEOUT) ? IO_TIMEOUT : UNMAPPED_TIMEOUT;
  localparam int MAX_COUNT = (MAX_TO > 15) ? MAX_TO : 15;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_STEP    = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_ERR     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  // Bit 1 clear marks a memory region (fixed wait), set marks a timed region.
  localparam logic [1:0] RG_PROM  = 2'd0;
  localparam logic [1:0] RG_SRAM  = 2'd1;
  localparam logic [1:0] RG_IO    = 2'd2;
  localparam logic [1:0] RG_UNMAP = 2'd3;

  logic          asreq;
  logic          dtreq;
  logic          lower;
  logic          io_hit;
  logic          upper;
  logic          prom_sel;
  logic          sram_sel;
  logic [1:0]    cur_region;
  logic [CW-1:0] cur_load;

  logic [2:0]    state;
  logic [2:0]    state_d;
  logic [1:0]    region;
  logic [1:0]    region_d;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic          stepped;
  logic          stepped_d;

  assign asreq  = RUN_IN & AS_IN;
  assign dtreq  = asreq & (UDS_IN | LDS_IN);
  assign lower  = (ADDR_IN[23:20] == 4'h0);
  assign io_hit = (ADDR_IN[23:20] == IO_BASE);
  assign upper  = (ADDR_IN[23:20] == PROM_BASE);

  // Reads of the low area hit PROM until the first low-area write exits the overlay.
  assign prom_sel = upper | (lower & ~WR_IN & ~BOOTSTRAPPED);
  assign sram_sel = lower & ~prom_sel;

  assign PROMCS0 = asreq & prom_sel & UDS_IN;
  assign PROMCS1 = asreq & prom_sel & LDS_IN;
  assign SRAMCS0 = asreq & sram_sel & UDS_IN;
  assign SRAMCS1 = asreq & sram_sel & LDS_IN;
  assign OE      = asreq & (prom_sel | sram_sel) & ~WR_IN;
  assign IOSEL   = dtreq & io_hit;

  // Classify the current address and pick the counter load for that region.
  always_comb begin
    if (prom_sel) begin
      cur_region = RG_PROM;
      cur_load   = CW'(PROM_WAIT);
    end else if (sram_sel) begin
      cur_region = RG_SRAM;
      cur_load   = CW'(SRAM_WAIT);
    end else if (io_hit) begin
      cur_region = RG_IO;
      cur_load   = CW'(IO_TIMEOUT);
    end else begin
      cur_region = RG_UNMAP;
      cur_load   = CW'(UNMAPPED_TIMEOUT);
    end
  end

  // Wait-state / handshake / timeout / stepper sequencing.
  always_comb begin
    state_d   = state;
    region_d  = region;
    count_d   = count;
    stepped_d = stepped;
    case (state)
      S_IDLE: begin
        stepped_d = 1'b0;
        if (dtreq) begin
          region_d = cur_region;
          count_d  = cur_load;
          if (!cur_region[1] && (cur_load == '0)) begin
            state_d   = STEPEN_IN ? S_STEP : S_ACK;
            stepped_d = STEPEN_IN;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!dtreq) begin
          state_d = S_IDLE;
        end else if (((region == RG_IO) && IO_ACK_IN) ||
                     (!region[1] && (count == CW'(1)))) begin
          state_d   = STEPEN_IN ? S_STEP : S_ACK;
          stepped_d = STEPEN_IN;
        end else if (count == CW'(1)) begin
          state_d = S_ERR;
        end else begin
          count_d = count - CW'(1);
        end
      end
      S_STEP: begin
        if (!dtreq) begin
          state_d = S_IDLE;
        end else if (STEP_IN) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!dtreq) begin
          state_d = stepped ? S_RELEASE : S_IDLE;
        end
      end
      S_ERR: begin
        if (!dtreq) begin
          state_d = S_IDLE;
        end
      end
      S_RELEASE: begin
        // Wait for the switch to open so one press acknowledges one cycle.
        if (!STEP_IN) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered DTACK/BERR and the sticky overlay-exit flag.
  always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      state        <= S_IDLE;
      region       <= RG_PROM;
      count        <= '0;
      stepped      <= 1'b0;
      DTACK        <= 1'b0;
      BERR         <= 1'b0;
      BOOTSTRAPPED <= 1'b0;
    end else begin
      state   <= state_d;
      region  <= region_d;
      count   <= count_d;
      stepped <= stepped_d;
      DTACK   <= (state_d == S_ACK);
      BERR    <= (state_d == S_ERR);
      if (dtreq & WR_IN & lower) begin
        BOOTSTRAPPED <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
